// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one shared full-adder slice,
// sequenced LSB first over WIDTH cycles.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             c_q, c_d;
    logic             cout_q, cout_d;
    logic             done_q, done_d;

    logic             p, g, t, s_bit, c_next;
    logic [WIDTH:0]   res_ext;

    half_adder u_ha0 (
        .x (sa_q[0]),
        .y (sb_q[0]),
        .s (p),
        .c (g)
    );

    half_adder u_ha1 (
        .x (p),
        .y (c_q),
        .s (s_bit),
        .c (t)
    );

    assign c_next  = g | t;
    // New bit enters at the MSB; the LSB falls off.
    assign res_ext = {s_bit, res_q};

    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        res_d   = res_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        cout_d  = cout_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    sa_d    = a;
                    sb_d    = b;
                    c_d     = cin;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sa_d  = sa_q >> 1;
                sb_d  = sb_q >> 1;
                res_d = res_ext[WIDTH:1];
                c_d   = c_next;
                if (cnt_q == LAST) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                sum_d   = res_q;
                cout_d  = c_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            cout_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            cout_q  <= cout_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

module half_adder (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);
    assign s = x ^ y;
    assign c = x & y;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8 and WIDTH=1).
// Arithmetic reference is plain a+b+cin.
module tb_serial_add_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, cin, busy, done, cout;
    logic [7:0] a, b, sum;
    logic       start1, a1, b1, cin1;
    logic       busy1, done1, sum1, cout1;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    serial_add_ctrl #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    serial_add_ctrl #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .rst   (rst),
        .start (start1),
        .a     (a1),
        .b     (b1),
        .cin   (cin1),
        .busy  (busy1),
        .done  (done1),
        .sum   (sum1),
        .cout  (cout1)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] s;
        logic       co;
    } vec_t;

    vec_t tbl[7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic do_op(input  logic [7:0] ta,
                         input  logic [7:0] tb,
                         input  logic       tc,
                         output logic [8:0] res,
                         output int         lat,
                         output int         bcnt);
        a = ta;
        b = tb;
        cin = tc;
        start = 1'b1;
        tick();
        start = 1'b0;
        a = 8'($urandom);
        b = 8'($urandom);
        cin = 1'($urandom);
        lat = 0;
        bcnt = busy ? 1 : 0;
        while (!done && lat < 50) begin
            tick();
            lat++;
            if (busy) bcnt++;
        end
        res = {cout, sum};
    endtask

    initial begin
        logic [8:0] res, exp9, last;
        logic [8:0] q[$];
        logic [1:0] e2;
        int lat, bcnt, nd, dk;
        logic have_last;
        logic [7:0] ra, rb;
        logic rc;

        tbl[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
        tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        tbl[2] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1};
        tbl[3] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        tbl[4] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        tbl[5] = '{8'h80, 8'h80, 1'b1, 8'h01, 1'b1};
        tbl[6] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};

        rst = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        cin = 1'b0;
        start1 = 1'b0;
        a1 = 1'b0;
        b1 = 1'b0;
        cin1 = 1'b0;
        tick();
        tick();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_sum", 32'(sum), 0);
        chk("rst_cout", 32'(cout), 0);
        chk("rst_busy1", 32'(busy1), 0);
        rst = 1'b0;
        tick();

        foreach (tbl[i]) begin
            do_op(tbl[i].a, tbl[i].b, tbl[i].cin,
                  res, lat, bcnt);
            chk($sformatf("tbl%0d_lat", i), lat, 9);
            chk($sformatf("tbl%0d_busy", i), bcnt, 9);
            chk($sformatf("tbl%0d_sum", i),
                32'(res[7:0]), 32'(tbl[i].s));
            chk($sformatf("tbl%0d_cout", i),
                32'(res[8]), 32'(tbl[i].co));
            tick();
            chk($sformatf("tbl%0d_pulse", i),
                32'(done), 0);
        end

        // start pulses at RUN edge 3 and in DONE must be ignored
        a = 8'h01;
        b = 8'h01;
        cin = 1'b0;
        start = 1'b1;
        tick();
        nd = 0;
        dk = 0;
        for (int k = 1; k <= 20; k++) begin
            start = (k == 3 || k == 9);
            a = start ? 8'h80 : 8'h00;
            b = start ? 8'h80 : 8'h00;
            tick();
            if (done) begin
                nd++;
                dk = k;
                chk("ign_sum", 32'(sum), 32'h02);
                chk("ign_cout", 32'(cout), 0);
            end
        end
        start = 1'b0;
        chk("ign_ndone", nd, 1);
        chk("ign_when", dk, 9);
        chk("ign_busy", 32'(busy), 0);

        // reset at RUN edge 4
        a = 8'h12;
        b = 8'h34;
        cin = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rmid_busy", 32'(busy), 0);
        chk("rmid_sum", 32'(sum), 0);
        chk("rmid_cout", 32'(cout), 0);
        nd = 0;
        repeat (15) begin
            tick();
            if (done) nd++;
        end
        chk("rmid_nodone", nd, 0);
        do_op(8'h12, 8'h34, 1'b0, res, lat, bcnt);
        chk("rmid_again", 32'(res), 32'h046);
        chk("rmid_lat", lat, 9);
        tick();

        // reset while in DONE
        a = 8'hF0;
        b = 8'h0F;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (8) tick();
        chk("rdone_busy_pre", 32'(busy), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rdone_done", 32'(done), 0);
        chk("rdone_sum", 32'(sum), 0);
        chk("rdone_busy", 32'(busy), 0);
        nd = 0;
        repeat (12) begin
            tick();
            if (done) nd++;
        end
        chk("rdone_nodone", nd, 0);

        // rst wins over start
        rst = 1'b1;
        start = 1'b1;
        tick();
        rst = 1'b0;
        start = 1'b0;
        chk("rprio_busy", 32'(busy), 0);
        tick();
        chk("rprio_busy2", 32'(busy), 0);

        // start held high: accept every 10 cycles
        have_last = 1'b0;
        last = '0;
        start = 1'b1;
        for (int k = 0; k < 1000; k++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            cin = 1'($urandom);
            if (k % 10 == 0)
                q.push_back({1'b0, a} + {1'b0, b} + 9'(cin));
            tick();
            if (done) begin
                chk("b2b_phase", k % 10, 9);
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL b2b_extra got=done want=none");
                end else begin
                    exp9 = q.pop_front();
                    chk("b2b_res", 32'({cout, sum}), 32'(exp9));
                end
                last = {cout, sum};
                have_last = 1'b1;
            end else if (have_last) begin
                chk("b2b_hold", 32'({cout, sum}), 32'(last));
            end
        end
        start = 1'b0;
        chk("b2b_left", q.size(), 0);
        tick();
        tick();

        // random ops with random gaps
        for (int n = 0; n < 1000; n++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            exp9 = {1'b0, ra} + {1'b0, rb} + 9'(rc);
            do_op(ra, rb, rc, res, lat, bcnt);
            chk("rnd_res", 32'(res), 32'(exp9));
            chk("rnd_lat", lat, 9);
            repeat ($urandom_range(0, 2)) tick();
        end

        // WIDTH=1 instance, all input combinations
        for (int i = 0; i < 8; i++) begin
            a1 = i[0];
            b1 = i[1];
            cin1 = i[2];
            e2 = 2'(i[0]) + 2'(i[1]) + 2'(i[2]);
            start1 = 1'b1;
            tick();
            start1 = 1'b0;
            chk("w1_busy", 32'(busy1), 1);
            tick();
            chk("w1_early", 32'(done1), 0);
            tick();
            chk("w1_done", 32'(done1), 1);
            chk("w1_res", 32'({cout1, sum1}), 32'(e2));
            tick();
            chk("w1_pulse", 32'(done1), 0);
            chk("w1_hold", 32'({cout1, sum1}), 32'(e2));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
